// File: rtl/arcanoid_ball_engine_if.sv
// rtl/arcanoid_ball_engine_if.sv - game-side/engine-side signal bundle for the ball physics engine
interface arcanoid_ball_engine_if #(
    parameter int POS_W   = 12,
    parameter int SPEED_W = 4
);
    logic               frame_tick;
    logic [POS_W-1:0]   paddle_x;
    logic               launch;
    logic               new_game;
    logic               brick_hit;
    logic [SPEED_W-1:0] speed;
    logic [POS_W-1:0]   ball_x;
    logic [POS_W-1:0]   ball_y;
    logic               bounce;
    logic               ball_lost;
    logic [2:0]         lives;
    logic               game_over;

    modport master (
        output frame_tick, paddle_x, launch, new_game, brick_hit, speed,
        input  ball_x, ball_y, bounce, ball_lost, lives, game_over
    );

    modport slave (
        input  frame_tick, paddle_x, launch, new_game, brick_hit, speed,
        output ball_x, ball_y, bounce, ball_lost, lives, game_over
    );
endinterface

// File: rtl/arcanoid_ball_engine.sv
// rtl/arcanoid_ball_engine.sv - per-frame ball physics, lives and attach/launch/lost control
// Optional PADDLE_ANGLE_EN: outer-quarter paddle hits double the x step and steer dx away from centre.
module arcanoid_ball_engine #(
    parameter int H_RES       = 1024,
    parameter int V_RES       = 768,
    parameter int POS_W       = 12,
    parameter int BALL_SIZE   = 16,
    parameter int PADDLE_W    = 128,
    parameter int PADDLE_Y    = 700,
    parameter int SPEED_W     = 4,
    parameter int LIVES       = 3,
    parameter int LOST_FRAMES = 60
) (
    input  logic                    pclk,
    input  logic                    reset,
    arcanoid_ball_engine_if.slave   bus
);
    localparam int SW     = POS_W + 2;
    localparam int X_MAX  = H_RES - BALL_SIZE;
    localparam int Y_REST = PADDLE_Y - BALL_SIZE;
    localparam int CNT_W  = $clog2(LOST_FRAMES + 1);

    localparam logic signed [SW-1:0] S_ZERO = '0;
    localparam logic signed [SW-1:0] S_ONE  = SW'(1);
    localparam logic signed [SW-1:0] S_BS   = SW'(BALL_SIZE);
    localparam logic signed [SW-1:0] S_PY   = SW'(PADDLE_Y);
    localparam logic signed [SW-1:0] S_PW   = SW'(PADDLE_W);
    localparam logic signed [SW-1:0] S_XMAX = SW'(X_MAX);
    localparam logic signed [SW-1:0] S_YMAX = SW'(V_RES - BALL_SIZE);
    localparam logic signed [SW-1:0] S_ATT  = SW'(PADDLE_W / 2 - BALL_SIZE / 2);
`ifdef PADDLE_ANGLE_EN
    localparam logic signed [SW-1:0] S_QW   = SW'(PADDLE_W / 4);
    localparam logic signed [SW-1:0] S_HALF = SW'(BALL_SIZE / 2);
`endif

    typedef enum logic [1:0] {ATTACHED, FLYING, LOST} state_t;

    state_t             state;
    logic [POS_W-1:0]   ball_x_q, ball_y_q;
    logic               dx_neg, dy_pos, brick_pend, bounce_q, lost_q;
    logic [2:0]         lives_q;
    logic [CNT_W-1:0]   lost_cnt;
`ifdef PADDLE_ANGLE_EN
    logic               wide, f_wide;
    logic signed [SW-1:0] ctr;
`endif

    logic signed [SW-1:0] s, xs, cx, cy, px, nx, ny, att_full;
    logic [POS_W-1:0]   att_x, f_x, f_y;
    logic               pend, hit_pad, hit_top, hit_bot, hit_brk, x_bnc, f_dxn, f_dyp, f_bnc;

    // Candidate next-frame values for FLYING; the register block only commits them on frame_tick.
    always_comb begin
        pend = brick_pend | bus.brick_hit;
        s    = (bus.speed == '0) ? S_ONE : $signed(SW'(bus.speed));
`ifdef PADDLE_ANGLE_EN
        xs   = wide ? (s <<< 1) : s;
`else
        xs   = s;
`endif
        cx       = $signed(SW'(ball_x_q));
        cy       = $signed(SW'(ball_y_q));
        px       = $signed(SW'(bus.paddle_x));
        nx       = dx_neg ? cx - xs : cx + xs;
        ny       = dy_pos ? cy + s : cy - s;
        att_full = px + S_ATT;
        att_x    = (att_full > S_XMAX) ? POS_W'(X_MAX) : att_full[POS_W-1:0];

        hit_pad = dy_pos && (ny + S_BS >= S_PY) && (cy + S_BS <= S_PY)
                  && (nx + S_BS > px) && (nx < px + S_PW);
        hit_top = (ny < S_ZERO);
        hit_bot = !hit_pad && (ny > S_YMAX);
        hit_brk = pend && !hit_pad && !hit_top && !hit_bot;

        f_dxn = dx_neg;
        f_x   = nx[POS_W-1:0];
        x_bnc = 1'b0;
`ifdef PADDLE_ANGLE_EN
        f_wide = wide;
        ctr    = nx + S_HALF;
        if (hit_pad) begin
            if (ctr < px + S_QW) begin
                f_wide = 1'b1;
                f_dxn  = 1'b1;
            end else if (ctr >= px + S_PW - S_QW) begin
                f_wide = 1'b1;
                f_dxn  = 1'b0;
            end else begin
                f_wide = 1'b0;
            end
        end
`endif
        if (nx < S_ZERO) begin
            f_x   = '0;
            f_dxn = 1'b0;
            x_bnc = 1'b1;
        end else if (nx > S_XMAX) begin
            f_x   = POS_W'(X_MAX);
            f_dxn = 1'b1;
            x_bnc = 1'b1;
        end

        f_y   = ny[POS_W-1:0];
        f_dyp = dy_pos;
        if (hit_pad) begin
            f_y   = POS_W'(Y_REST);
            f_dyp = 1'b0;
        end else if (hit_top) begin
            f_y   = '0;
            f_dyp = 1'b1;
        end else if (hit_brk) begin
            f_y   = ball_y_q;
            f_dyp = !dy_pos;
        end
        f_bnc = x_bnc | hit_pad | hit_top | hit_brk;
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            state      <= ATTACHED;
            lives_q    <= 3'(LIVES);
            dx_neg     <= 1'b0;
            dy_pos     <= 1'b0;
            ball_x_q   <= '0;
            ball_y_q   <= POS_W'(Y_REST);
            bounce_q   <= 1'b0;
            lost_q     <= 1'b0;
            brick_pend <= 1'b0;
            lost_cnt   <= '0;
`ifdef PADDLE_ANGLE_EN
            wide       <= 1'b0;
`endif
        end else if (bus.new_game) begin
            state      <= ATTACHED;
            lives_q    <= 3'(LIVES);
            dx_neg     <= 1'b0;
            dy_pos     <= 1'b0;
            bounce_q   <= 1'b0;
            lost_q     <= 1'b0;
            brick_pend <= 1'b0;
            lost_cnt   <= '0;
        end else begin
            bounce_q <= 1'b0;
            lost_q   <= 1'b0;
            if (!bus.frame_tick) begin
                brick_pend <= brick_pend | bus.brick_hit;
            end else begin
                brick_pend <= 1'b0;
                case (state)
                    ATTACHED: begin
                        ball_x_q <= att_x;
                        ball_y_q <= POS_W'(Y_REST);
                        if (bus.launch && lives_q != 3'd0) begin
                            state  <= FLYING;
                            dx_neg <= 1'b0;
                            dy_pos <= 1'b0;
`ifdef PADDLE_ANGLE_EN
                            wide   <= 1'b0;
`endif
                        end
                    end
                    FLYING: begin
                        ball_x_q <= f_x;
                        ball_y_q <= f_y;
                        dx_neg   <= f_dxn;
                        dy_pos   <= f_dyp;
                        bounce_q <= f_bnc;
`ifdef PADDLE_ANGLE_EN
                        wide     <= f_wide;
`endif
                        if (hit_bot) begin
                            state  <= LOST;
                            lost_q <= 1'b1;
                            if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
                        end
                    end
                    default: begin
                        if (lost_cnt == CNT_W'(LOST_FRAMES - 1)) begin
                            state    <= ATTACHED;
                            lost_cnt <= '0;
                            dx_neg   <= 1'b0;
                            dy_pos   <= 1'b0;
                        end else begin
                            lost_cnt <= lost_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.ball_x    = ball_x_q;
    assign bus.ball_y    = ball_y_q;
    assign bus.bounce    = bounce_q;
    assign bus.ball_lost = lost_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = (lives_q == 3'd0);
endmodule

// File: tb/tb_arcanoid_ball_engine.sv
// tb/tb_arcanoid_ball_engine.sv - directed bench with a frame-level reference model for arcanoid_ball_engine
module tb_arcanoid_ball_engine;
    logic pclk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    arcanoid_ball_engine_if #(.POS_W(12), .SPEED_W(4)) bus ();

    arcanoid_ball_engine dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Reference model: one whole-frame update in plain integer arithmetic (state 0=attached, 1=flying, 2=lost).
    int m_x, m_y, m_dx, m_dy, m_lives, m_cnt, m_st;
    bit m_pend, m_bnc, m_lost, m_wide;

    always @(posedge pclk) begin
        int  s, stx, nx, ny, px, c;
        bit  p, pad;
        m_bnc  = 0;
        m_lost = 0;
        px     = int'(bus.paddle_x);
        if (!reset) begin
            m_st = 0; m_lives = 3; m_dx = 1; m_dy = -1;
            m_x = 0; m_y = 684; m_pend = 0; m_cnt = 0; m_wide = 0;
        end else if (bus.new_game) begin
            m_st = 0; m_lives = 3; m_dx = 1; m_dy = -1; m_cnt = 0; m_pend = 0;
        end else if (!bus.frame_tick) begin
            m_pend = m_pend | bus.brick_hit;
        end else begin
            p      = m_pend | bus.brick_hit;
            m_pend = 0;
            if (m_st == 0) begin
                m_x = (px + 56 > 1008) ? 1008 : px + 56;
                m_y = 684;
                if (bus.launch && m_lives != 0) begin
                    m_st = 1; m_dx = 1; m_dy = -1; m_wide = 0;
                end
            end else if (m_st == 1) begin
                s   = (bus.speed == 0) ? 1 : int'(bus.speed);
                stx = m_wide ? 2 * s : s;
                nx  = m_x + m_dx * stx;
                ny  = m_y + m_dy * s;
                pad = (m_dy == 1) && (ny + 16 >= 700) && (m_y + 16 <= 700) && (nx + 16 > px) && (nx < px + 128);
`ifdef PADDLE_ANGLE_EN
                if (pad) begin
                    c = nx + 8;
                    if (c < px + 32) begin m_wide = 1; m_dx = -1; end
                    else if (c >= px + 96) begin m_wide = 1; m_dx = 1; end
                    else m_wide = 0;
                end
`endif
                if (nx < 0) begin m_x = 0; m_dx = 1; m_bnc = 1; end
                else if (nx > 1008) begin m_x = 1008; m_dx = -1; m_bnc = 1; end
                else m_x = nx;
                if (pad) begin m_y = 684; m_dy = -1; m_bnc = 1; end
                else if (ny < 0) begin m_y = 0; m_dy = 1; m_bnc = 1; end
                else if (ny > 752) begin
                    m_y = ny; m_st = 2; m_lost = 1;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                end
                else if (p) begin m_dy = -m_dy; m_bnc = 1; end
                else m_y = ny;
            end else begin
                if (m_cnt == 59) begin m_st = 0; m_cnt = 0; m_dx = 1; m_dy = -1; end
                else m_cnt++;
            end
        end
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            check("ball_x",    int'(bus.ball_x),    m_x);
            check("ball_y",    int'(bus.ball_y),    m_y);
            check("bounce",    int'(bus.bounce),    int'(m_bnc));
            check("ball_lost", int'(bus.ball_lost), int'(m_lost));
            check("lives",     int'(bus.lives),     m_lives);
            check("game_over", int'(bus.game_over), (m_lives == 0) ? 1 : 0);
        end
    end

    task automatic cyc();
        @(posedge pclk);
        #2;
    endtask

    task automatic tick();
        cyc();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
    endtask

    task automatic tick_brick();
        cyc();
        bus.frame_tick = 1'b1;
        bus.brick_hit  = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        bus.brick_hit  = 1'b0;
    endtask

    task automatic lose_ball(input int exp_lives);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 400) begin
            tick();
            n++;
            if (bus.ball_lost) seen = 1;
        end
        check("lost_seen", int'(seen), 1);
        check("lit_lives", int'(bus.lives), exp_lives);
        repeat (60) tick();
        tick();
    endtask

    initial begin
        int n;
        bit seen;
        reset          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.paddle_x   = '0;
        bus.launch     = 1'b0;
        bus.new_game   = 1'b0;
        bus.brick_hit  = 1'b0;
        bus.speed      = '0;
        cyc();
        cyc();
        chk_en = 1'b1;
        reset  = 1'b1;
        check("rst_ball_x", int'(bus.ball_x), 0);
        check("rst_ball_y", int'(bus.ball_y), 684);
        check("rst_lives",  int'(bus.lives), 3);
        check("rst_bounce", int'(bus.bounce), 0);

        bus.paddle_x = 12'd500;
        tick();
        check("att_x_500", int'(bus.ball_x), 556);
        bus.paddle_x = 12'd1000;
        tick();
        check("att_x_clamp", int'(bus.ball_x), 1008);

        bus.paddle_x = 12'd944;
        bus.launch   = 1'b1;
        tick();
        bus.launch   = 1'b0;
        check("launch_x", int'(bus.ball_x), 1000);
        bus.speed = 4'd10;
        tick();
        check("rwall_x", int'(bus.ball_x), 1008);
        check("rwall_y", int'(bus.ball_y), 674);
        check("rwall_bounce", int'(bus.bounce), 1);
        cyc();
        check("bounce_pulse", int'(bus.bounce), 0);

        bus.speed = 4'd8;
        tick_brick();
        check("brick_y", int'(bus.ball_y), 674);
        check("brick_bounce", int'(bus.bounce), 1);
        tick();
        check("down_y", int'(bus.ball_y), 682);

        bus.paddle_x  = 12'd900;
        cyc();
        bus.brick_hit = 1'b1;
        cyc();
        bus.brick_hit = 1'b0;
        tick();
        check("pad_y", int'(bus.ball_y), 684);
        check("pad_bounce", int'(bus.bounce), 1);
        tick();
        check("pend_clr_y", int'(bus.ball_y), 676);
        tick_brick();
        check("brick2_y", int'(bus.ball_y), 676);

        bus.paddle_x = 12'd0;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (bus.ball_lost) seen = 1;
        end
        check("miss_ticks", n, 10);
        check("miss_lives", int'(bus.lives), 2);
        check("miss_y", int'(bus.ball_y), 756);
        repeat (60) tick();
        check("frozen_x", int'(bus.ball_x), 888);
        tick();
        check("reattach_x", int'(bus.ball_x), 56);
        check("reattach_y", int'(bus.ball_y), 684);

        bus.speed  = 4'd15;
        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        repeat (46) tick();
        check("top_y", int'(bus.ball_y), 0);
        check("top_x", int'(bus.ball_x), 746);
        check("top_bounce", int'(bus.bounce), 1);
        bus.speed = 4'd0;
        tick();
        check("spd0_y", int'(bus.ball_y), 1);
        check("spd0_x", int'(bus.ball_x), 747);

        bus.paddle_x = 12'd3000;
        bus.speed    = 4'd12;
        lose_ball(1);
        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        lose_ball(0);
        bus.launch = 1'b1;
        repeat (3) tick();
        bus.launch = 1'b0;
        check("over_y", int'(bus.ball_y), 684);
        check("over_flag", int'(bus.game_over), 1);

        cyc();
        bus.frame_tick = 1'b1;
        bus.new_game   = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        bus.new_game   = 1'b0;
        check("ng_lives", int'(bus.lives), 3);
        check("ng_over", int'(bus.game_over), 0);

        bus.launch = 1'b1;
        tick();
        bus.launch = 1'b0;
        bus.speed  = 4'd5;
        tick();
        tick();
        check("fly_y", int'(bus.ball_y), 674);
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("mrst_x", int'(bus.ball_x), 0);
        check("mrst_y", int'(bus.ball_y), 684);
        check("mrst_lives", int'(bus.lives), 3);
        tick();
        check("mrst_att_x", int'(bus.ball_x), 1008);
        cyc();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
